// File: rtl/data_write_buffer.sv
// Posted-store write buffer between a CPU data port and a single-master bus.
// Optional store-to-load forwarding is enabled by defining WBUF_LOAD_FORWARD_EN.
module data_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     data_sram_en,
    input  logic [3:0]               data_sram_wen,
    input  logic [31:0]              data_sram_addr,
    input  logic [31:0]              data_sram_wdata,
    output logic [31:0]              data_sram_rdata,
    output logic                     cpu_stall,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   wbuf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     addr_mem  [DEPTH];
    logic [3:0]      wen_mem   [DEPTH];
    logic [31:0]     wdata_mem [DEPTH];

    logic            is_store, is_load, full, push, pop;
    logic            fwd_take;
    logic [31:0]     fwd_data;

    assign is_store = data_sram_en && (data_sram_wen != 4'b0000);
    assign is_load  = data_sram_en && (data_sram_wen == 4'b0000);
    // Fullness is judged on registered count only, so a pop this cycle never admits a store this cycle.
    assign full     = (count_q == CW'(DEPTH));
    assign push     = is_store && !full;
    assign pop      = (state_q == ST_WRITE) && mem_ack;

`ifdef WBUF_LOAD_FORWARD_EN
    logic [DEPTH-1:0] slot_hit;
    logic             fwd_full;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] slot_idx;
            assign slot_idx     = rd_ptr_q + PW'(gi);
            assign slot_hit[gi] = (CW'(gi) < count_q) &&
                                  (addr_mem[slot_idx][31:2] == data_sram_addr[31:2]);
        end
    endgenerate

    // Later slots are younger, so the last hit in age order is the newest matching store.
    always_comb begin
        fwd_full = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_hit[i]) begin
                fwd_full = (wen_mem[rd_ptr_q + PW'(i)] == 4'b1111);
                fwd_data = wdata_mem[rd_ptr_q + PW'(i)];
            end
        end
    end

    assign fwd_take = is_load && (|slot_hit) && fwd_full;
`else
    assign fwd_take = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= data_sram_addr;
            wen_mem[wr_ptr_q]   <= data_sram_wen;
            wdata_mem[wr_ptr_q] <= data_sram_wdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fwd_take) begin
                    rdata_d = fwd_data;
                    state_d = ST_RESP;
                end else if (count_q != '0) begin
                    state_d = ST_WRITE;
                end else if (is_load) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

    // Bus fields decode from the registered state, so they read as zero while reset holds IDLE.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_wstrb = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_WRITE) begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_wstrb = wen_mem[rd_ptr_q];
            mem_addr  = addr_mem[rd_ptr_q];
            mem_wdata = wdata_mem[rd_ptr_q];
        end else if (state_q == ST_READ) begin
            mem_req   = 1'b1;
            mem_addr  = {data_sram_addr[31:2], 2'b00};
        end
    end

    assign cpu_stall       = resetn && ((is_store && full) || (is_load && (state_q != ST_RESP)));
    assign data_sram_rdata = rdata_q;
    assign wbuf_count      = count_q;

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed bench for data_write_buffer: store posting, full stall, drain-before-load,
// forwarding (both builds of WBUF_LOAD_FORWARD_EN) and mid-transaction reset.
module tb_data_write_buffer;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [2:0]  wbuf_count;

    int n_checks = 0;
    int n_errors = 0;

    data_write_buffer #(.DEPTH(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .cpu_stall       (cpu_stall),
        .mem_req         (mem_req),
        .mem_wr          (mem_wr),
        .mem_wstrb       (mem_wstrb),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .wbuf_count      (wbuf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_store(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = data;
    endtask

    task automatic cpu_load(input logic [31:0] addr);
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = addr;
        data_sram_wdata = 32'h0;
    endtask

    task automatic cpu_idle();
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
    endtask

    // Wait (bounded) for a bus request, check its fields, then acknowledge it for one cycle.
    task automatic bus_serve(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [31:0] rdata);
        int waited;
        waited = 0;
        while (!mem_req && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_req_seen"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_wr"}, {31'd0, mem_wr}, {31'd0, wr});
        check({tag, "_addr"}, mem_addr, addr);
        check({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
        $display("bus %s: wr=%0d addr=%h wstrb=%b wdata=%h", tag, mem_wr, mem_addr, mem_wstrb, mem_wdata);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        resetn          = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        mem_rdata       = 32'h0;
        mem_ack         = 1'b0;
        tick();
        cpu_load(32'h0000_0040);
        #1;
        check("rst_stall_low", {31'd0, cpu_stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_count", {29'd0, wbuf_count}, 32'd0);
        check("rst_rdata", data_sram_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        cpu_idle();
        tick();
        resetn = 1'b1;
        tick();

        // Single store, ack arriving on the second request cycle.
        cpu_store(32'h0000_0100, 4'b1111, 32'h1122_3344);
        #1;
        check("st1_no_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        cpu_idle();
        check("st1_count1", {29'd0, wbuf_count}, 32'd1);
        tick();
        check("st1_req_c1", {31'd0, mem_req}, 32'd1);
        check("st1_addr", mem_addr, 32'h0000_0100);
        check("st1_wstrb", {28'd0, mem_wstrb}, 32'hF);
        check("st1_wdata", mem_wdata, 32'h1122_3344);
        tick();
        check("st1_req_c2", {31'd0, mem_req}, 32'd1);
        check("st1_addr_held", mem_addr, 32'h0000_0100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st1_count0", {29'd0, wbuf_count}, 32'd0);
        check("st1_req_drop", {31'd0, mem_req}, 32'd0);
        $display("store 0x100 done");

        // Five back-to-back stores into a four-entry buffer with the bus stalled.
        for (int i = 0; i < 4; i++) begin
            cpu_store(32'h10 + 32'(i * 4), 4'b1111, 32'hA000_0000 + 32'(i));
            #1;
            check("burst_no_stall", {31'd0, cpu_stall}, 32'd0);
            tick();
        end
        cpu_store(32'h20, 4'b1111, 32'hA000_0004);
        #1;
        check("burst_full_count", {29'd0, wbuf_count}, 32'd4);
        check("burst_5th_stall", {31'd0, cpu_stall}, 32'd1);
        tick();
        check("burst_still_stall", {31'd0, cpu_stall}, 32'd1);
        check("burst_head_addr", mem_addr, 32'h10);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("burst_after_pop", {29'd0, wbuf_count}, 32'd3);
        check("burst_stall_released", {31'd0, cpu_stall}, 32'd0);
        tick();
        cpu_idle();
        check("burst_5th_enq", {29'd0, wbuf_count}, 32'd4);
        bus_serve("burst1", 1'b1, 32'h14, 4'hF, 32'h0);
        bus_serve("burst2", 1'b1, 32'h18, 4'hF, 32'h0);
        bus_serve("burst3", 1'b1, 32'h1C, 4'hF, 32'h0);
        bus_serve("burst4", 1'b1, 32'h20, 4'hF, 32'h0);
        check("burst_drained", {29'd0, wbuf_count}, 32'd0);

        // Minimum-latency load on an empty buffer, unaligned address.
        cpu_load(32'h0000_1007);
        #1;
        check("ld_first_stall", {31'd0, cpu_stall}, 32'd1);
        check("ld_first_noreq", {31'd0, mem_req}, 32'd0);
        tick();
        check("ld_read_req", {31'd0, mem_req}, 32'd1);
        check("ld_read_wr", {31'd0, mem_wr}, 32'd0);
        check("ld_read_addr", mem_addr, 32'h0000_1004);
        check("ld_read_wstrb", {28'd0, mem_wstrb}, 32'h0);
        mem_rdata = 32'h5A5A_1234;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        check("ld_resp_stall", {31'd0, cpu_stall}, 32'd0);
        check("ld_resp_rdata", data_sram_rdata, 32'h5A5A_1234);
        cpu_idle();
        tick();
        $display("load 0x1007 done");

        // Two stores then a load: writes drain in order before the read.
        cpu_store(32'h40, 4'b1111, 32'h0000_0040);
        tick();
        cpu_store(32'h44, 4'b1100, 32'h0000_0044);
        tick();
        cpu_load(32'h0000_0200);
        #1;
        check("dr_load_stall", {31'd0, cpu_stall}, 32'd1);
        bus_serve("dr_w0", 1'b1, 32'h40, 4'b1111, 32'h0);
        check("dr_stall_mid", {31'd0, cpu_stall}, 32'd1);
        bus_serve("dr_w1", 1'b1, 32'h44, 4'b1100, 32'h0);
        bus_serve("dr_rd", 1'b0, 32'h200, 4'b0000, 32'hDEAD_BEEF);
        check("dr_resp_stall", {31'd0, cpu_stall}, 32'd0);
        check("dr_resp_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        cpu_idle();
        tick();

        // Full-word store followed by a load of the same word.
        cpu_store(32'h300, 4'b1111, 32'hCAFE_F00D);
        tick();
        cpu_load(32'h0000_0300);
        #1;
        check("fw_load_stall", {31'd0, cpu_stall}, 32'd1);
        tick();
`ifdef WBUF_LOAD_FORWARD_EN
        check("fw_no_bus_read", {31'd0, mem_req}, 32'd0);
        check("fw_resp_stall", {31'd0, cpu_stall}, 32'd0);
        check("fw_resp_rdata", data_sram_rdata, 32'hCAFE_F00D);
        cpu_idle();
        bus_serve("fw_w", 1'b1, 32'h300, 4'hF, 32'h0);
`else
        check("fw_drain_first", {31'd0, mem_wr}, 32'd1);
        bus_serve("fw_w", 1'b1, 32'h300, 4'hF, 32'h0);
        bus_serve("fw_rd", 1'b0, 32'h300, 4'h0, 32'hCAFE_F00D);
        check("fw_resp_stall", {31'd0, cpu_stall}, 32'd0);
        check("fw_resp_rdata", data_sram_rdata, 32'hCAFE_F00D);
        cpu_idle();
        tick();
`endif
        check("fw_count0", {29'd0, wbuf_count}, 32'd0);

        // Partial-word store to the same word always drains then reads.
        cpu_store(32'h300, 4'b0011, 32'h0000_BEEF);
        tick();
        cpu_load(32'h0000_0300);
        #1;
        check("pw_load_stall", {31'd0, cpu_stall}, 32'd1);
        bus_serve("pw_w", 1'b1, 32'h300, 4'b0011, 32'h0);
        bus_serve("pw_rd", 1'b0, 32'h300, 4'b0000, 32'h7777_BEEF);
        check("pw_resp_stall", {31'd0, cpu_stall}, 32'd0);
        check("pw_resp_rdata", data_sram_rdata, 32'h7777_BEEF);
        cpu_idle();
        tick();

        // Reset pulsed during a write with three buffered entries.
        cpu_store(32'h500, 4'b1111, 32'h5);
        tick();
        cpu_store(32'h504, 4'b1111, 32'h6);
        tick();
        cpu_store(32'h508, 4'b1111, 32'h7);
        tick();
        cpu_idle();
        check("rr_pre_count", {29'd0, wbuf_count}, 32'd3);
        check("rr_pre_req", {31'd0, mem_req}, 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("rr_req_async", {31'd0, mem_req}, 32'd0);
        check("rr_count_async", {29'd0, wbuf_count}, 32'd0);
        #1;
        resetn = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rr_no_bus", {31'd0, mem_req}, 32'd0);
            check("rr_count_stays0", {29'd0, wbuf_count}, 32'd0);
            tick();
        end
        $display("reset during write done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_write_buffer.md
DATA_WRITE_BUFFER -- requirements
Module: data_write_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered store entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 data_sram_en  input  1  CPU data access request, held stable while cpu_stall=1.
REQ-005 data_sram_wen  input  4  byte write enables; 4'b0000 = load, non-zero = store.
REQ-006 data_sram_addr  input  32  byte address.
REQ-007 data_sram_wdata  input  32  store data.
REQ-008 data_sram_rdata  output  32  registered load data.
REQ-009 cpu_stall  output  1  CPU pipeline hold request.
REQ-010 mem_req  output  1  bus request, held until mem_ack.
REQ-011 mem_wr  output  1  1 = write, 0 = read.
REQ-012 mem_wstrb  output  4  write byte strobes.
REQ-013 mem_addr  output  32  bus address.
REQ-014 mem_wdata  output  32  bus write data.
REQ-015 mem_rdata  input  32  bus read data, valid when mem_ack=1 on a read.
REQ-016 mem_ack  input  1  one-cycle transfer completion.
REQ-017 wbuf_count  output  $clog2(DEPTH)+1  current number of occupied entries.

Function
REQ-018 Buffer is an in-order FIFO of {addr, wen, wdata}; read/write pointers wrap modulo DEPTH.
REQ-019 Store with count<DEPTH: enqueued on that clock edge, cpu_stall=0 in that cycle.
REQ-020 Store with count==DEPTH: cpu_stall=1; enqueue occurs at the first edge where count<DEPTH at the start of the cycle. A same-cycle pop does not free space for the current cycle.
REQ-021 Bus FSM states: IDLE, WRITE, READ, RESP.
REQ-022 IDLE: when count>0, go to WRITE and present the head entry (mem_req=1, mem_wr=1); otherwise go to READ when a load is pending and count==0.
REQ-023 WRITE: mem_* fields stay stable until mem_ack. On mem_ack, pop the head and return to IDLE.
REQ-024 READ: mem_req=1, mem_wr=0, mem_addr={data_sram_addr[31:2],2'b00}, mem_wstrb=0. On mem_ack, register mem_rdata into data_sram_rdata and go to RESP.
REQ-025 RESP: one cycle with cpu_stall=0 so the CPU consumes the load, then return to IDLE.
REQ-026 A load raises cpu_stall=1 combinationally from its first cycle until RESP. Loads never bypass older buffered stores.
REQ-027 Minimum load latency with an empty buffer and zero-wait bus: request cycle, READ/ack cycle, RESP cycle; data is visible in RESP.
REQ-028 data_sram_en=0 leaves CPU-side state untouched; draining continues regardless of CPU activity.
REQ-029 A simultaneous enqueue and pop (count<DEPTH) leaves count unchanged.

Reset
REQ-030 While resetn=0, asynchronously: FSM=IDLE, pointers=0, wbuf_count=0, mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, data_sram_rdata=0, cpu_stall=0.
REQ-031 Reset mid-transaction discards all buffered stores and any outstanding read; a mem_ack arriving after reset release is ignored in IDLE.

Configuration
REQ-032 Macro WBUF_LOAD_FORWARD_EN defined: a load whose word address matches a buffered entry is served from the newest matching entry when that entry has wen=4'b1111. In that case data_sram_rdata is registered in one cycle and cpu_stall=0 the next cycle (RESP), with no bus read. A match with a partial wen falls back to drain-then-read.
REQ-033 Macro WBUF_LOAD_FORWARD_EN undefined: every load drains the buffer, then reads the bus (REQ-022..027).

Verification
REQ-034 Store 0x11223344 to 0x00000100, wen 1111, ack after 2 cycles -> mem_req with addr 0x100, wstrb 1111, held 2 cycles; wbuf_count goes 1 then 0.
REQ-035 Five back-to-back stores, DEPTH=4, mem_ack held 0 -> cpu_stall=1 on the 5th store; it is enqueued the cycle after the first ack.
REQ-036 Two stores, then a load from 0x200 returning mem_rdata 0xDEADBEEF -> both writes complete before the read; data_sram_rdata=0xDEADBEEF in RESP.
REQ-037 With forwarding on: store 0xCAFEF00D, wen 1111, to 0x300 with bus stalled, then load 0x300 -> rdata=0xCAFEF00D, no read on the bus; with wen 0011 -> drain then bus read.
REQ-038 resetn pulsed low during WRITE with 3 entries -> mem_req=0 and wbuf_count=0 immediately; no further bus writes after release.
